// File: rtl/aud_player.sv
// aud_player: I2S playback engine. It walks SRAM addresses 0..i_end_addr and
// shifts each sample out MSB-first on the DAC data line, one BCLK after each
// DACLRCK edge.
// Optional build macro: AUD_PLAYER_STEREO_DUP_EN. When it is defined, the
// right channel repeats the left sample. When it is undefined, the right
// channel sends zeros.
module aud_player #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrc,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_dacdat,
    output logic [2:0]        o_state,
    output logic              o_done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SEND  = 3'd2,
        ST_PAUSE = 3'd3
    } state_t;

    localparam logic [4:0]        LAST_BIT = 5'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              lrc_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic              last_q, last_d;
    logic              done_q, done_d;

    logic              lrc_fall;
    logic              lrc_rise;
    logic [DATA_W-1:0] right_word;

    assign lrc_fall = lrc_q & ~i_lrc;
    assign lrc_rise = ~lrc_q & i_lrc;

`ifdef AUD_PLAYER_STEREO_DUP_EN
    assign right_word = hold_q;
`else
    assign right_word = '0;
`endif

    // The serial bit is driven only while sending. Reset therefore clears
    // it through the state register, without waiting for a clock edge.
    assign o_dacdat  = (state_q == ST_SEND) & shreg_q[DATA_W-1];
    assign o_address = addr_q;
    assign o_state   = state_q;
    assign o_done    = done_q;

    // Register all state. The LRC copy is updated in every state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            lrc_q     <= 1'b0;
            addr_q    <= '0;
            hold_q    <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lrc_q     <= i_lrc;
            addr_q    <= addr_d;
            hold_q    <= hold_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic. Priority is stop, then pause, then LRC-edge sequencing.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        hold_d    = hold_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                last_d = 1'b0;
                if (i_start) begin
                    state_d = ST_WAIT;
                end
            end

            ST_PAUSE: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                    last_d  = 1'b0;
                end else if (!i_pause && i_start) begin
                    // Any partially sent word is dropped. The next fall
                    // reloads the same address from its MSB.
                    state_d   = ST_WAIT;
                    bit_cnt_d = '0;
                end
            end

            ST_WAIT, ST_SEND: begin
                if (i_stop) begin
                    state_d   = ST_IDLE;
                    addr_d    = '0;
                    last_d    = 1'b0;
                    bit_cnt_d = '0;
                end else if (i_pause) begin
                    state_d   = ST_PAUSE;
                    bit_cnt_d = '0;
                end else if (lrc_fall) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        addr_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        hold_d    = i_sram_data;
                        shreg_d   = i_sram_data;
                        bit_cnt_d = '0;
                        state_d   = ST_SEND;
                    end
                end else if (lrc_rise) begin
                    // Advance during the right half-frame. This gives the
                    // SRAM a whole half-frame to settle before the next fall.
                    shreg_d   = right_word;
                    bit_cnt_d = '0;
                    state_d   = ST_SEND;
                    if (addr_q == i_end_addr) begin
                        last_d = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end else if (state_q == ST_SEND) begin
                    shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_WAIT;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aud_player.sv
// tb_aud_player: directed bench for aud_player. The expected right-channel
// word follows AUD_PLAYER_STEREO_DUP_EN, so build the bench with the same
// macro setting as the RTL.
module tb_aud_player;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lrc, start, pause, stop;
    logic [19:0] end_addr;
    logic [15:0] sram_data;
    logic [19:0] address;
    logic        dacdat, done;
    logic [2:0]  state;

    // Second instance with a 3-bit address. It makes the address wrap
    // reachable in a short run.
    logic        w_start, w_zero;
    logic [2:0]  w_end, w_addr, w_state;
    logic [15:0] w_data;
    logic        w_dacdat, w_done;

    logic [15:0] mem [16];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          w_done_cnt = 0;

    always #5 clk = ~clk;

    assign sram_data = mem[address[3:0]];
    assign w_data    = mem[{1'b0, w_addr}];
    assign w_zero    = 1'b0;

    aud_player #(.DATA_W(16), .ADDR_W(20)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_start(start),
        .i_pause(pause), .i_stop(stop), .i_end_addr(end_addr),
        .i_sram_data(sram_data), .o_address(address), .o_dacdat(dacdat),
        .o_state(state), .o_done(done)
    );

    aud_player #(.DATA_W(16), .ADDR_W(3)) dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_start(w_start),
        .i_pause(w_zero), .i_stop(w_zero), .i_end_addr(w_end),
        .i_sram_data(w_data), .o_address(w_addr), .o_dacdat(w_dacdat),
        .o_state(w_state), .o_done(w_done)
    );

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (w_done === 1'b1) w_done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [15:0] right_exp(input logic [15:0] l);
`ifdef AUD_PLAYER_STEREO_DUP_EN
        return l;
`else
        return 16'h0000;
`endif
    endfunction

    // One 20-BCLK half-frame. Call it at a negedge. The LRC level changes
    // here, so the DUT sees the edge at the next posedge T. Bit k is
    // sampled on the negedge after T+k, and the tail after T+16.
    task automatic half_frame(input logic lv, output logic [15:0] w, output logic tail);
        lrc = lv;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            w[15-k] = dacdat;
        end
        @(negedge clk);
        tail = dacdat;
        repeat (3) @(negedge clk);
    endtask

    // Move to the right half-frame, then pulse start so the next edge is a fall.
    task automatic arm_main();
        lrc = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [15:0] w;
    logic        t;
    logic [2:0]  wrap_exp [11];

    initial begin
        rst_n = 1'b0; lrc = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        end_addr = 20'd2; w_start = 1'b0; w_end = 3'd7;
        for (int i = 0; i < 16; i++) mem[i] = 16'(i * 16'h1357) ^ 16'hC0DE;
        mem[0] = 16'hA5C3; mem[1] = 16'h0001; mem[2] = 16'h8000;
        wrap_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd2};

        repeat (3) @(negedge clk);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_dacdat", 32'(dacdat), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three-sample clip, end address 2.
        arm_main();
        for (int s = 0; s < 3; s++) begin
            half_frame(1'b0, w, t);
            chk($sformatf("clip_left%0d", s), 32'(w), 32'(mem[s]));
            chk($sformatf("clip_ltail%0d", s), 32'(t), 32'd0);
            chk($sformatf("clip_laddr%0d", s), 32'(address), 32'(s));
            half_frame(1'b1, w, t);
            chk($sformatf("clip_right%0d", s), 32'(w), 32'(right_exp(mem[s])));
            chk($sformatf("clip_raddr%0d", s), 32'(address), (s < 2) ? 32'(s + 1) : 32'd2);
        end
        chk("clip_no_early_done", 32'(done_cnt), 32'd0);
        lrc = 1'b0;
        @(negedge clk);
        chk("clip_done", 32'(done), 32'd1);
        chk("clip_end_state", 32'(state), 32'd0);
        chk("clip_end_addr", 32'(address), 32'd0);
        @(negedge clk);
        chk("clip_done_one_cycle", 32'(done), 32'd0);
        repeat (18) @(negedge clk);

        // Pause mid-word at address 1, then resume.
        mem[1] = 16'hFFFF;
        end_addr = 20'd9;
        arm_main();
        half_frame(1'b0, w, t);
        chk("p_left0", 32'(w), 32'(mem[0]));
        half_frame(1'b1, w, t);
        chk("p_addr1", 32'(address), 32'd1);
        lrc = 1'b0;
        repeat (5) @(negedge clk);
        chk("p_pre_dacdat", 32'(dacdat), 32'd1);
        pause = 1'b1;
        @(negedge clk);
        chk("p_dacdat", 32'(dacdat), 32'd0);
        chk("p_state", 32'(state), 32'd3);
        chk("p_address", 32'(address), 32'd1);
        pause = 1'b0;
        repeat (14) @(negedge clk);
        lrc = 1'b1;
        repeat (5) @(negedge clk);
        chk("p_hold_state", 32'(state), 32'd3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        half_frame(1'b0, w, t);
        chk("p_resume_word", 32'(w), 32'hFFFF);
        chk("p_resume_addr", 32'(address), 32'd1);
        half_frame(1'b1, w, t);
        for (int s = 2; s < 7; s++) begin
            half_frame(1'b0, w, t);
            chk($sformatf("seq_left%0d", s), 32'(w), 32'(mem[s]));
            half_frame(1'b1, w, t);
        end
        chk("stop_pre_addr", 32'(address), 32'd7);

        // Stop while sending address 7.
        lrc = 1'b0;
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_state", 32'(state), 32'd0);
        chk("stop_address", 32'(address), 32'd0);
        chk("stop_dacdat", 32'(dacdat), 32'd0);
        repeat (17) @(negedge clk);
        chk("stop_no_done", 32'(done_cnt), 32'd1);

        // A single-sample clip.
        end_addr = 20'd0;
        arm_main();
        half_frame(1'b0, w, t);
        chk("one_left", 32'(w), 32'(mem[0]));
        half_frame(1'b1, w, t);
        chk("one_addr", 32'(address), 32'd0);
        lrc = 1'b0;
        @(negedge clk);
        chk("one_done", 32'(done), 32'd1);
        chk("one_state", 32'(state), 32'd0);
        repeat (19) @(negedge clk);
        chk("one_done_count", 32'(done_cnt), 32'd2);

        // Asynchronous reset in the middle of a word.
        end_addr = 20'd2;
        arm_main();
        half_frame(1'b0, w, t);
        half_frame(1'b1, w, t);
        lrc = 1'b0;
        repeat (3) @(negedge clk);
        chk("ar_pre_dacdat", 32'(dacdat), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_dacdat", 32'(dacdat), 32'd0);
        chk("ar_state", 32'(state), 32'd0);
        chk("ar_address", 32'(address), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        arm_main();
        half_frame(1'b0, w, t);
        chk("ar_first_word", 32'(w), 32'(mem[0]));
        chk("ar_first_addr", 32'(address), 32'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;

        // Address wrap on the 3-bit instance. Lowering the end address
        // below the current address forces the count through 7 -> 0.
        lrc = 1'b1;
        repeat (4) @(negedge clk);
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i == 3) w_end = 3'd2;
            half_frame(1'b0, w, t);
            half_frame(1'b1, w, t);
            chk($sformatf("wrap_addr%0d", i), 32'(w_addr), 32'(wrap_exp[i]));
        end
        lrc = 1'b0;
        @(negedge clk);
        chk("wrap_done", 32'(w_done), 32'd1);
        chk("wrap_end_addr", 32'(w_addr), 32'd0);
        chk("wrap_state", 32'(w_state), 32'd0);
        chk("wrap_dacdat", 32'(w_dacdat), 32'd0);
        repeat (3) @(negedge clk);
        chk("wrap_done_count", 32'(w_done_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
